// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the vectored interrupt controller.
//   state_e  - request FSM state encoding (IDLE / REQ)
//   id_width - width of an interrupt index for a given source count
package intc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // ceil(log2(n)), never less than 1 so a 2-source block still has an id bit.
    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/intc_arb.sv
// intc_arb: combinational find-first arbiter.
//   RR_MODE = 0 : winner is the highest set index of eligible.
//   RR_MODE = 1 : search starts at (last_grant + 1) mod NUM_IRQ and ascends
//                 with wrap; the first set bit wins.
// Ports:
//   eligible   in   NUM_IRQ  candidate sources
//   last_grant in   ID_W     most recently acknowledged source (RR base)
//   winner     out  ID_W     selected source index (0 when none)
//   valid      out  1        at least one candidate present
module intc_arb
    import intc_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    parameter  int RR_MODE = 0,
    localparam int ID_W    = id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [2*NUM_IRQ-1:0] doubled;
    logic [NUM_IRQ-1:0]   rotated;
    int                   start;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    always_comb begin
        winner  = '0;
        valid   = |eligible;
        doubled = {eligible, eligible};
        rotated = '0;
        start   = 0;
        if (RR_MODE != 0) begin
            // Rotate so bit 0 of 'rotated' is the search base; the doubled
            // copy supplies the wrapped-around upper bits.
            start   = (int'(last_grant) + 1) % NUM_IRQ;
            rotated = NUM_IRQ'(doubled >> start);
            // Descending scan: the lowest offset is assigned last and wins.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (rotated[i]) begin
                    winner = ID_W'((start + i) % NUM_IRQ);
                end
            end
        end else begin
            // Ascending scan: the highest index is assigned last and wins.
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (eligible[i]) begin
                    winner = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/intc_vec.sv
// intc_vec: vectored interrupt controller with per-source enable and
// edge/level mode, fixed-priority or round-robin arbitration, and a
// request/acknowledge handshake to the CPU.
// Ports:
//   clk       in   1        clock, rising edge
//   rst       in   1        asynchronous active-high reset
//   irq       in   NUM_IRQ  raw interrupt lines (synchronous to clk)
//   irq_en    in   NUM_IRQ  per-source enable (0 = masked from arbitration)
//   irq_edge  in   NUM_IRQ  per-source mode (1 = rising edge, 0 = level)
//   int_ack   in   1        CPU acknowledge of the current request
//   int_req   out  1        registered interrupt request
//   int_id    out  ID_W     registered index of the requested source
//   pending   out  NUM_IRQ  registered pending vector
module intc_vec
    import intc_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    parameter  int RR_MODE = 0,
    localparam int ID_W    = id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic               int_ack,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_IRQ-1:0] pending
);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_d_q, irq_d_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [ID_W-1:0]    winner;
    logic               win_valid;

    // Pending vector: edge sources latch rises and are cleared by an ack,
    // with a same-cycle rise taking precedence; level sources track irq.
    always_comb begin
        irq_d_d  = irq;
        rise     = irq & ~irq_d_q;
        eligible = pending_q & irq_en;
        ack_clr  = '0;
        if ((state_q == REQ) && int_ack && irq_edge[int_id_q]) begin
            ack_clr[int_id_q] = 1'b1;
        end
        pending_d = (irq_edge & ((pending_q & ~ack_clr) | rise))
                  | (~irq_edge & irq);
    end

    intc_arb #(
        .NUM_IRQ (NUM_IRQ),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .winner     (winner),
        .valid      (win_valid)
    );

    // Request FSM. The id is captured on entry to REQ and frozen until the
    // ack, regardless of later masking or deassertion of the source.
    always_comb begin
        state_d      = state_q;
        int_id_d     = int_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = REQ;
                    int_id_d = winner;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d      = IDLE;
                    last_grant_d = int_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: irq_d resets to 0, so a line already high when reset releases is
    // seen as a rising edge on the first clocked cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_d_q      <= '0;
            pending_q    <= '0;
            int_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_IRQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            irq_d_q      <= irq_d_d;
            pending_q    <= pending_d;
            int_id_q     <= int_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // int_req is a decode of the state flop, so it is registered and drops
    // with the asynchronous reset.
    assign int_req = (state_q == REQ);
    assign int_id  = int_id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_intc_vec.sv
// tb_intc_vec: self-checking bench for intc_vec (NUM_IRQ = 8). A fixed-
// priority and a round-robin instance share all inputs; each is compared
// every cycle against a behavioural model, plus directed scenario checks.
module tb_intc_vec;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq;
    logic [N-1:0] irq_en;
    logic [N-1:0] irq_edge;
    logic         int_ack;

    logic         req_f, req_r;
    logic [2:0]   id_f, id_r;
    logic [N-1:0] pend_f, pend_r;

    int n_vec;
    int n_err;

    // Behavioural model state, index 0 = fixed, 1 = round-robin.
    logic [N-1:0] m_irqd;
    logic [N-1:0] m_pend [2];
    bit           m_busy [2];
    int           m_id   [2];
    int           m_last [2];

    intc_vec #(.NUM_IRQ(N), .RR_MODE(0)) dut_fix (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .irq_en   (irq_en),
        .irq_edge (irq_edge),
        .int_ack  (int_ack),
        .int_req  (req_f),
        .int_id   (id_f),
        .pending  (pend_f)
    );

    intc_vec #(.NUM_IRQ(N), .RR_MODE(1)) dut_rr (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .irq_en   (irq_en),
        .irq_edge (irq_edge),
        .int_ack  (int_ack),
        .int_req  (req_r),
        .int_id   (id_r),
        .pending  (pend_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Winner by the arbitration rules: highest index (fixed), or first set
    // bit ascending from last+1 with wrap (round-robin).
    function automatic int pick(input int inst, input logic [N-1:0] elig, input int last);
        if (inst == 0) begin
            for (int i = N - 1; i >= 0; i--) if (elig[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last + k) % N;
                if (elig[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_irqd = '0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_busy[m] = 1'b0;
            m_id[m]   = 0;
            m_last[m] = N - 1;
        end
    endtask

    // One clock edge of the model, from the inputs present before the edge.
    task automatic model_step();
        logic [N-1:0] rise;
        rise = irq & ~m_irqd;
        for (int m = 0; m < 2; m++) begin
            logic [N-1:0] elig;
            logic [N-1:0] next;
            elig = m_pend[m] & irq_en;
            for (int b = 0; b < N; b++) begin
                bit cleared;
                cleared = m_busy[m] && int_ack && (m_id[m] == b) && irq_edge[b];
                if (irq_edge[b]) next[b] = rise[b] | (m_pend[m][b] & !cleared);
                else             next[b] = irq[b];
            end
            if (!m_busy[m]) begin
                if (elig != 0) begin
                    m_busy[m] = 1'b1;
                    m_id[m]   = pick(m, elig, m_last[m]);
                end
            end else if (int_ack) begin
                m_busy[m] = 1'b0;
                m_last[m] = m_id[m];
            end
            m_pend[m] = next;
        end
        m_irqd = irq;
    endtask

    task automatic compare();
        check("fix.int_req", req_f,  m_busy[0]);
        check("fix.int_id",  id_f,   m_id[0]);
        check("fix.pending", pend_f, m_pend[0]);
        check("rr.int_req",  req_r,  m_busy[1]);
        check("rr.int_id",   id_r,   m_id[1]);
        check("rr.pending",  pend_r, m_pend[1]);
    endtask

    // Advance one edge, update the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check("reset.int_req", req_f, 0);
        check("reset.pending", pend_r, 0);
        compare();
        rst = 1'b0;
    endtask

    int exp_seq [4] = '{0, 7, 0, 7};
    int got_n;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        irq      = '0;
        irq_en   = '1;
        irq_edge = '1;
        int_ack  = 1'b0;
        model_reset();

        // Fixed priority, two simultaneous edge pulses (bits 5 and 2).
        do_reset();
        irq = 8'h24;
        tick();
        check("t31.pend_set", pend_f, 8'h24);
        check("t31.no_req_yet", req_f, 0);
        irq = 8'h00;
        tick();
        check("t31.req", req_f, 1);
        check("t31.id5", id_f, 5);
        int_ack = 1'b1;
        tick();
        check("t31.ack_idle", req_f, 0);
        check("t31.pend_after_ack", pend_f, 8'h04);
        int_ack = 1'b0;
        tick();
        check("t31.id2", id_f, 2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
        check("t31.final_req", req_f, 0);
        check("t31.final_pend", pend_f, 8'h00);

        // Round-robin between two held level sources, acked immediately.
        irq_edge = 8'h00;
        irq      = 8'h81;
        do_reset();
        int_ack = 1'b1;
        got_n   = 0;
        for (int c = 0; c < 20 && got_n < 4; c++) begin
            tick();
            if (req_r) begin
                check("t32.rr_seq", id_r, exp_seq[got_n]);
                got_n++;
            end
        end
        check("t32.rr_seq_count", got_n, 4);
        int_ack = 1'b0;
        irq     = 8'h00;

        // Ack clear and new rise on the same edge source in one cycle.
        irq_edge = 8'hFF;
        do_reset();
        irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        check("t33.id3", id_f, 3);
        irq     = 8'h08;
        int_ack = 1'b1;
        tick();
        check("t33.set_wins", pend_f[3], 1);
        check("t33.idle", req_f, 0);
        irq     = 8'h00;
        int_ack = 1'b0;
        tick();
        check("t33.rereq", req_f, 1);
        check("t33.rereq_id", id_f, 3);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();

        // Masked source keeps pending, becomes eligible once unmasked.
        irq_en = 8'h00;
        irq    = 8'h10;
        tick();
        irq = 8'h00;
        tick();
        tick();
        check("t34.masked_noreq", req_f, 0);
        check("t34.masked_pend", pend_f, 8'h10);
        irq_en = 8'h10;
        tick();
        check("t34.unmask_req", req_f, 1);
        check("t34.unmask_id", id_f, 4);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;

        // Request held through masking; ack in IDLE is ignored.
        irq_en = 8'hFF;
        irq    = 8'h40;
        tick();
        irq = 8'h00;
        tick();
        check("t35.id6", id_f, 6);
        irq_en = 8'hBF;
        repeat (3) tick();
        check("t35.hold_req", req_f, 1);
        check("t35.hold_id", id_f, 6);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("t35.acked", req_f, 0);
        irq_en = 8'h00;
        irq    = 8'h02;
        tick();
        irq     = 8'h00;
        int_ack = 1'b1;
        tick();
        tick();
        check("t35.idle_ack_req", req_f, 0);
        check("t35.idle_ack_pend", pend_f, 8'h02);
        int_ack = 1'b0;

        // Asynchronous reset in REQ, then irq high across reset release.
        irq_en = 8'hFF;
        tick();
        check("t36.in_req", req_f, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t36.async_fix", req_f, 0);
        check("t36.async_rr", req_r, 0);
        irq = 8'h02;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        check("t36.first_edge", req_f, 0);
        tick();
        check("t36.second_req", req_f, 1);
        check("t36.second_id", id_f, 1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;

        // Randomised traffic against the model.
        irq = 8'h00;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            irq     = N'($urandom);
            irq_en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            if ($urandom_range(0, 15) == 0) irq_edge = N'($urandom);
            int_ack = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
